mio_bus_ctrl: RTL and testbench

Memory/IO bus controller directly downstream of the single-cycle CPU core. It consumes the core's Addr_out, Data_out, MemRW and CPU_MIO outputs and returns Data_in and MIO_ready.
- Decodes the address into a block-RAM region and three IO registers: LED, switches, free-running counter.
- Inserts RAM_LAT wait states for RAM accesses; the core stalls while MIO_ready is low.

---
 rtl/mio_bus_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mio_bus_ctrl
//
// Memory/IO bus controller sitting directly downstream of the single-cycle CPU
// core. It decodes each core access into one of four targets and returns read
// data plus a ready handshake:
//   - block RAM : addr_in[31:RAM_AW+2] == 0, with RAM_LAT wait states
//   - LED reg   : 0xF000_0000, read/write
//   - counter   : 0xF000_0004, read/write, free-running
//   - switches  : 0xE000_0000, read only
// Any other address is unmapped: reads return 0 and writes are dropped.
//
// The core stalls while mio_ready is low. mio_ready is purely combinational
// from the FSM state and cpu_mio.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   asynchronous active-low reset (0 = reset)
//   cpu_mio    in   access request, held with addr/data/mem_rw until ready
//   mem_rw     in   1 = write, 0 = read
//   addr_in    in   byte address (bits [1:0] ignored, word accesses only)
//   wdata_in   in   write data
//   rdata_out  out  registered read data, holds until the next read completes
//   mio_ready  out  access complete / bus idle
//   ram_addr   out  RAM word address, registered at accept
//   ram_wdata  out  RAM write data, registered at accept
//   ram_we     out  RAM write strobe, one cycle (first WAIT cycle)
//   ram_rdata  in   RAM read data, valid RAM_LAT cycles after accept
//   sw_in      in   switch inputs
//   led_out    out  LED register
//   cnt_out    out  free-running counter value
// -----------------------------------------------------------------------------
module mio_bus_ctrl #(
    parameter int RAM_LAT = 2,   // 1..7
    parameter int RAM_AW  = 10,
    parameter int LED_W   = 16   // 1..32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_mio,
    input  logic              mem_rw,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       rdata_out,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic [31:0]       cnt_out
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Word addresses (byte address >> 2) of the IO registers
    localparam logic [29:0] LED_WADDR = 30'h3C00_0000;  // 0xF000_0000
    localparam logic [29:0] CNT_WADDR = 30'h3C00_0001;  // 0xF000_0004
    localparam logic [29:0] SW_WADDR  = 30'h3800_0000;  // 0xE000_0000

    // The wait counter is loaded with RAM_LAT-1 so that data is captured on
    // the RAM_LAT-th edge after accept.
    localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,     state_d;
    logic [2:0]        wait_q,      wait_d;
    logic              write_q,     write_d;     // RAM access in flight is a write
    logic              we_q,        we_d;
    logic [RAM_AW-1:0] ram_addr_q,  ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic [LED_W-1:0]  led_q,       led_d;
    logic [31:0]       cnt_q,       cnt_d;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [29:0] word_addr;
    logic        hit_ram;
    logic        hit_led;
    logic        hit_cnt;
    logic        hit_sw;
    logic [31:0] io_rdata;

    // Byte-lane bits carry no information for word-only accesses.
    logic        unused_byte_bits;
    assign unused_byte_bits = ^addr_in[1:0];

    assign word_addr = addr_in[31:2];
    assign hit_ram   = (addr_in[31:RAM_AW+2] == '0);
    assign hit_led   = (word_addr == LED_WADDR);
    assign hit_cnt   = (word_addr == CNT_WADDR);
    assign hit_sw    = (word_addr == SW_WADDR);

    // IO read mux; unmapped addresses fall through to zero. The counter value
    // is the one before this edge's increment because cnt_q is sampled here.
    always_comb begin
        io_rdata = 32'h0;
        if (hit_led) begin
            io_rdata = 32'(led_q);
        end else if (hit_cnt) begin
            io_rdata = cnt_q;
        end else if (hit_sw) begin
            io_rdata = 32'(sw_in);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        write_d     = write_q;
        we_d        = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        led_d       = led_q;
        cnt_d       = cnt_q + 32'd1;   // wraps naturally at 0xFFFF_FFFF

        case (state_q)
            ST_IDLE: begin
                if (cpu_mio) begin
                    if (hit_ram) begin
                        ram_addr_d  = addr_in[RAM_AW+1:2];
                        ram_wdata_d = wdata_in;
                        wait_d      = LAT_M1;
                        write_d     = mem_rw;
                        // Strobe lands in the first WAIT cycle only.
                        we_d        = mem_rw;
                        state_d     = ST_WAIT;
                    end else begin
                        // IO and unmapped accesses complete on this edge.
                        if (mem_rw) begin
                            if (hit_led) begin
                                led_d = wdata_in[LED_W-1:0];
                            end
                            if (hit_cnt) begin
                                // A load replaces this cycle's increment.
                                cnt_d = wdata_in;
                            end
                        end else begin
                            rdata_d = io_rdata;
                        end
                        state_d = ST_DONE;
                    end
                end
            end

            ST_WAIT: begin
                if (wait_q == 3'd0) begin
                    if (!write_q) begin
                        rdata_d = ram_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end

            ST_DONE: begin
                // The core advances during DONE; a back-to-back request is
                // picked up in the following IDLE cycle.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers (asynchronous active-low reset; an in-flight write is
    // abandoned because the strobe register clears immediately)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= 3'd0;
            write_q     <= 1'b0;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            led_q       <= '0;
            cnt_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            write_q     <= write_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            led_q       <= led_d;
            cnt_q       <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mio_ready = ((state_q == ST_IDLE) && !cpu_mio) || (state_q == ST_DONE);
    assign rdata_out = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = we_q;
    assign led_out   = led_q;
    assign cnt_out   = cnt_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mio_bus_ctrl
//
// Directed bench for mio_bus_ctrl (RAM_LAT=2, RAM_AW=10, LED_W=16). Each bus
// access pushes its expected response into a queue; a monitor pops an entry
// whenever the DUT completes an access (cpu_mio && mio_ready) and compares
// read data, latency, RAM write-strobe count and RAM word address. Register
// side effects (LED, counter, reset values) are checked from the main flow.
// -----------------------------------------------------------------------------
module tb_mio_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_mio;
    logic        mem_rw;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic [31:0] rdata_out;
    logic        mio_ready;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic [31:0] cnt_out;

    mio_bus_ctrl #(
        .RAM_LAT (2),
        .RAM_AW  (10),
        .LED_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_mio   (cpu_mio),
        .mem_rw    (mem_rw),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .rdata_out (rdata_out),
        .mio_ready (mio_ready),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .cnt_out   (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple RAM model: address registered by the DUT, data read combinationally.
    logic [31:0] mem [0:1023];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        is_read;
        logic [31:0] rdata;
        int          lat;
        int          we;
        logic        is_ram;
        logic [9:0]  ra;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   req_cyc = 0;
    int   we_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            we_cnt = 0;
        end else begin
            if (ram_we) we_cnt++;
            if (cpu_mio && mio_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_ready: got completion at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %s addr=%h rdata=%h lat=%0d we_pulses=%0d",
                             e.is_read ? "RD" : "WR", e.addr, rdata_out, cyc - req_cyc, we_cnt);
                    chk("latency", 32'(cyc - req_cyc), 32'(e.lat));
                    chk("ram_we_pulses", 32'(we_cnt), 32'(e.we));
                    if (e.is_read) chk("rdata", rdata_out, e.rdata);
                    if (e.is_ram) chk("ram_addr", 32'(ram_addr), 32'(e.ra));
                end
                we_cnt = 0;
            end
        end
    end

    // Issue one access; entered and left at posedge+1 with cpu_mio dropped.
    // Calling it twice in a row gives a back-to-back request.
    task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
        exp_t e;
        bit   done;
        e.is_read = !rw;
        e.rdata   = exp_rd;
        e.is_ram  = (a[31:12] == 20'h0);
        e.lat     = e.is_ram ? 3 : 1;
        e.we      = (rw && e.is_ram) ? 1 : 0;
        e.ra      = a[11:2];
        e.addr    = a;
        exp_q.push_back(e);
        cpu_mio  = 1'b1;
        mem_rw   = rw;
        addr_in  = a;
        wdata_in = d;
        req_cyc  = cyc;
        done     = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (mio_ready) done = 1'b1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL timeout: got no mio_ready for addr %h expected ready within 20 cycles", a);
        end
        @(posedge clk);
        #1;
        cpu_mio = 1'b0;
    endtask

    task automatic idle(input int n);
        cpu_mio = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        cpu_mio  = 1'b0;
        mem_rw   = 1'b0;
        addr_in  = 32'h0;
        wdata_in = 32'h0;
        sw_in    = 16'h1234;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_cnt", cnt_out, 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ready", 32'(mio_ready), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_after_rst", cnt_out, 32'h1);

        // Idle bus keeps mio_ready high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(mio_ready), 32'h1);
        end
        @(posedge clk);
        #1;

        // RAM write then read
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        idle(1);
        issue(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        idle(1);

        // LED and switches
        issue(1'b1, 32'hF000_0000, 32'hFFFF_A5A5, 32'h0);
        chk("led_write", 32'(led_out), 32'h0000_A5A5);
        idle(1);
        issue(1'b0, 32'hF000_0000, 32'h0, 32'h0000_A5A5);
        idle(1);
        issue(1'b0, 32'hE000_0000, 32'h0, 32'h0000_1234);
        idle(1);

        // Counter load and wrap
        issue(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, 32'h0);
        chk("cnt_load_next", cnt_out, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("cnt_wrap", cnt_out, 32'h0);
        idle(4);                                   // counter now 4
        issue(1'b0, 32'hF000_0004, 32'h0, 32'h4);  // pre-increment value
        idle(1);

        // Unmapped accesses
        issue(1'b0, 32'h8000_0000, 32'h0, 32'h0);
        idle(1);
        issue(1'b1, 32'hF000_0004, 32'd1000, 32'h0);
        issue(1'b1, 32'h8000_0000, 32'hF000_0004, 32'h0);
        chk("cnt_after_unmapped_wr", cnt_out, 32'd1003);
        chk("led_after_unmapped_wr", 32'(led_out), 32'h0000_A5A5);
        issue(1'b1, 32'hF000_0008, 32'h0000_5A5A, 32'h0);
        chk("led_after_nearmiss_wr", 32'(led_out), 32'h0000_A5A5);
        idle(1);

        // Back-to-back RAM traffic
        issue(1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0);
        issue(1'b1, 32'h0000_0104, 32'h9ABC_DEF0, 32'h0);
        idle(1);
        issue(1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678);
        issue(1'b0, 32'h0000_0104, 32'h0, 32'h9ABC_DEF0);
        idle(1);

        // Reset during WAIT of a RAM write
        issue(1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0);
        idle(1);
        cpu_mio  = 1'b1;
        mem_rw   = 1'b1;
        addr_in  = 32'h0000_0020;
        wdata_in = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        chk("wait_ram_we", 32'(ram_we), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ram_we", 32'(ram_we), 32'h0);
        chk("midrst_led", 32'(led_out), 32'h0);
        chk("midrst_cnt", cnt_out, 32'h0);
        chk("midrst_rdata", rdata_out, 32'h0);
        chk("midrst_ram_wdata", ram_wdata, 32'h0);
        cpu_mio = 1'b0;
        #1;
        chk("midrst_ready", 32'(mio_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_after_midrst", cnt_out, 32'h1);
        issue(1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111);  // aborted write never landed
        idle(2);

        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_expectations: got %0d left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
